// File: rtl/operand_register_file.sv
// Operand register file feeding the ALU A/B inputs: R1..R4 and S1..S4 share one
// update function per cycle, selected per register by independent write enables.

module orf_reg #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = q;
        case (FunSel)
            3'b000: nxt = q - 1'b1;
            3'b001: nxt = q + 1'b1;
            3'b010: nxt = I;
            3'b011: nxt = '0;
            3'b100: nxt = {{(WIDTH-8){1'b0}}, I[7:0]};
            3'b101: nxt = {{(WIDTH-16){1'b0}}, I[15:0]};
            // byte shift-in drops the top byte of the current value
            3'b110: nxt = {q[WIDTH-9:0], I[7:0]};
            3'b111: nxt = {{(WIDTH-8){I[7]}}, I[7:0]};
            default: nxt = q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset)
            q <= '0;
        else if (en)
            q <= nxt;
    end
endmodule

module operand_register_file #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);
    localparam int NUM_REGS = 8;

    // index 0..3 = R1..R4, 4..7 = S1..S4, matching the read-select encoding
    logic [NUM_REGS-1:0]            wr_en;
    logic [NUM_REGS-1:0][WIDTH-1:0] regs;

    assign wr_en = {ScrSel, RegSel};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        orf_reg #(.WIDTH(WIDTH)) u_reg (
            .Clock  (Clock),
            .Reset  (Reset),
            .en     (wr_en[g]),
            .FunSel (FunSel),
            .I      (I),
            .q      (regs[g])
        );
    end

    // no bypass: reads always see pre-edge state
    assign OutA = regs[OutASel];
    assign OutB = regs[OutBSel];
endmodule

// File: tb/tb_operand_register_file.sv
// Directed table-driven bench for operand_register_file plus hand sequences
// for reset, no-bypass reads and reset in the middle of an increment run.

module tb_operand_register_file;
    logic        Clock;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [31:0] OutA;
    logic [31:0] OutB;

    int n_cmp = 0;
    int n_bad = 0;

    operand_register_file #(.WIDTH(32)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        rst_n;
        logic [2:0]  fs;
        logic [3:0]  rs;
        logic [3:0]  ss;
        logic [31:0] i;
        logic [2:0]  as;
        logic [2:0]  bs;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        Reset = 1'b1; FunSel = 3'b010; RegSel = 4'b0000; ScrSel = 4'b0000; I = '0;
    endtask

    initial begin
        // post-edge expectations, starting from the all-zero state after reset
        vt[0]  = '{1'b1, 3'b010, 4'b0010, 4'b0000, 32'h12345678, 3'd1, 3'd0, 32'h12345678, 32'h0};
        vt[1]  = '{1'b1, 3'b010, 4'b0000, 4'b0100, 32'h0000FFFF, 3'd1, 3'd6, 32'h12345678, 32'h0000FFFF};
        vt[2]  = '{1'b1, 3'b000, 4'b0001, 4'b0000, 32'h0,        3'd0, 3'd1, 32'hFFFFFFFF, 32'h12345678};
        vt[3]  = '{1'b1, 3'b001, 4'b0001, 4'b0000, 32'h0,        3'd0, 3'd6, 32'h0,        32'h0000FFFF};
        vt[4]  = '{1'b1, 3'b001, 4'b0001, 4'b0000, 32'h0,        3'd0, 3'd1, 32'h1,        32'h12345678};
        vt[5]  = '{1'b1, 3'b100, 4'b0100, 4'b0000, 32'h0000ABCD, 3'd2, 3'd0, 32'h000000CD, 32'h1};
        vt[6]  = '{1'b1, 3'b101, 4'b1000, 4'b0000, 32'h0000ABCD, 3'd3, 3'd2, 32'h0000ABCD, 32'h000000CD};
        vt[7]  = '{1'b1, 3'b111, 4'b0000, 4'b0001, 32'h0000ABCD, 3'd4, 3'd3, 32'hFFFFFFCD, 32'h0000ABCD};
        vt[8]  = '{1'b1, 3'b010, 4'b0000, 4'b0010, 32'h11223344, 3'd5, 3'd4, 32'h11223344, 32'hFFFFFFCD};
        vt[9]  = '{1'b1, 3'b110, 4'b0000, 4'b0010, 32'h0000ABCD, 3'd5, 3'd4, 32'h223344CD, 32'hFFFFFFCD};
        vt[10] = '{1'b1, 3'b011, 4'b0010, 4'b0000, 32'hFFFFFFFF, 3'd1, 3'd6, 32'h0,        32'h0000FFFF};
        vt[11] = '{1'b0, 3'b010, 4'b1111, 4'b1111, 32'hDEADBEEF, 3'd5, 3'd6, 32'h0,        32'h0};
        vt[12] = '{1'b1, 3'b010, 4'b0001, 4'b0000, 32'h5,        3'd0, 3'd3, 32'h5,        32'h0};
        vt[13] = '{1'b1, 3'b010, 4'b1000, 4'b0000, 32'h9,        3'd3, 3'd0, 32'h9,        32'h5};

        // reset with a load pending on every register
        Reset = 1'b0; FunSel = 3'b010; RegSel = 4'b1111; ScrSel = 4'b1111;
        I = 32'hDEADBEEF; OutASel = 3'd0; OutBSel = 3'd0;
        step();
        idle();
        for (int s = 0; s < 8; s++) begin
            OutASel = 3'(s); OutBSel = 3'(7 - s); #1;
            chk($sformatf("reset_A_sel%0d", s), OutA, 32'h0);
            chk($sformatf("reset_B_sel%0d", 7 - s), OutB, 32'h0);
        end

        for (int k = 0; k < 14; k++) begin
            Reset = vt[k].rst_n; FunSel = vt[k].fs; RegSel = vt[k].rs;
            ScrSel = vt[k].ss; I = vt[k].i; OutASel = vt[k].as; OutBSel = vt[k].bs;
            step();
            idle();
            chk($sformatf("vec%0d_A", k), OutA, vt[k].ea);
            chk($sformatf("vec%0d_B", k), OutB, vt[k].eb);
            // after both initial loads, untouched registers must still be zero
            if (k == 1) begin
                for (int s = 0; s < 8; s++) begin
                    if (s != 1 && s != 6) begin
                        OutASel = 3'(s); #1;
                        chk($sformatf("untouched_sel%0d", s), OutA, 32'h0);
                    end
                end
            end
        end

        // R1=5, R4=9, S1=0: one increment on three registers, old value seen pre-edge
        FunSel = 3'b001; RegSel = 4'b1001; ScrSel = 4'b0001; OutASel = 3'd0; OutBSel = 3'd4;
        #1;
        chk("nobypass_A_pre", OutA, 32'h5);
        chk("nobypass_B_pre", OutB, 32'h0);
        step();
        idle();
        OutASel = 3'd0; OutBSel = 3'd3; #1;
        chk("multi_R1", OutA, 32'h6);
        chk("multi_R4", OutB, 32'hA);
        OutASel = 3'd4; OutBSel = 3'd1; #1;
        chk("multi_S1", OutA, 32'h1);
        chk("multi_R2_hold", OutB, 32'h0);

        // increment R3 each cycle, then reset mid-run
        OutASel = 3'd2; OutBSel = 3'd2;
        FunSel = 3'b001; RegSel = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("inc_R3_%0d", c), OutA, 32'(c));
        end
        Reset = 1'b0;
        step();
        chk("midreset_R3", OutB, 32'h0);
        OutASel = 3'd0; #1;
        chk("midreset_R1", OutA, 32'h0);
        OutASel = 3'd2;
        Reset = 1'b1;
        step();
        chk("after_reset_R3", OutA, 32'h1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/operand_register_file.md
# operand_register_file

Register file that sources the A and B operands of the 32-bit arithmetic logic unit. It holds four general-purpose registers (R1–R4) and four scratch registers (S1–S4). Each register is updated on the clock edge under a shared 3-bit function select, from the 32-bit input bus. Two independent read ports drive the unit's A and B inputs directly.

## Interface
- WIDTH, 32: register and bus width. Byte/halfword functions below assume WIDTH ≥ 16.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- I  in  WIDTH  write-data bus (typically the ALU result or the memory/IR mux output).
- FunSel  in  3  update function applied to every enabled register this cycle.
- RegSel  in  4  active-high write enables for R1..R4 (bit 0 = R1, bit 3 = R4).
- ScrSel  in  4  active-high write enables for S1..S4 (bit 0 = S1, bit 3 = S4).
- OutASel  in  3  read select for OutA: 000..011 = R1..R4, 100..111 = S1..S4.
- OutBSel  in  3  read select for OutB, same encoding as OutASel.
- OutA  out  WIDTH  operand A to the ALU.
- OutB  out  WIDTH  operand B to the ALU.

## Operation
- Eight independent WIDTH-bit registers.
- On each rising edge, every register whose enable bit is 1 takes the function below. Registers with a 0 enable hold their value.
- FunSel encodings (R = current register value):
  - 000: decrement, R − 1 modulo 2^WIDTH (0 → all-ones).
  - 001: increment, R + 1 modulo 2^WIDTH (all-ones → 0).
  - 010: load, I.
  - 011: clear, 0.
  - 100: load byte, zero-extended: {0, I[7:0]}.
  - 101: load halfword, zero-extended: {0, I[15:0]}.
  - 110: byte shift-in, {R[WIDTH-9:0], I[7:0]}; the top byte is discarded.
  - 111: load byte, sign-extended: WIDTH-bit sign extension of I[7:0].
- Any number of the 8 enables may be active together. All enabled registers apply the same FunSel independently, each using its own current value.
- No carry or overflow is reported; increment and decrement wrap silently.
- Read ports are purely combinational muxes of register state.
  - OutA and OutB may select the same register.
  - There is no write-to-read bypass.
- All select encodings are defined, so there is no X/illegal-select case.

## Timing
- Reset (Reset = 0 at a rising edge): all eight registers become 0, regardless of FunSel, RegSel and ScrSel. Reset has priority over every update.
- During and after reset, OutA and OutB read 0 for any select until the first write.
- Deasserting Reset mid-sequence has no residual state; the first edge with Reset = 1 performs a normal update.
- Write latency is 1 cycle. A value written at edge n appears on OutA/OutB after edge n.
- A read in the same cycle as a write to the same register returns the pre-edge value. The ALU therefore sees old operands during a read-modify-write, which is required for R ← R op X sequences.
- Read latency is 0 cycles, combinational from the select and register state. There are no registered outputs.
- The enables are level qualifiers only; there is no handshake. The controller holds them for exactly the cycles in which updates are wanted.

## Test plan
- Reset then read: drive Reset = 0 for one edge with RegSel = 1111, FunSel = 010, I = 0xDEADBEEF. All 8 selects on OutA/OutB must read 0x00000000.
- Load and read both ports: load R2 = 0x12345678 (RegSel = 0010, FunSel = 010) and S3 = 0x0000FFFF (ScrSel = 0100). With OutASel = 001 and OutBSel = 110 the outputs must be 0x12345678 / 0x0000FFFF. All other registers must remain 0.
- Wrap-around: with R1 = 0, decrement, so R1 = 0xFFFFFFFF. Increment twice, so R1 = 0x00000001.
- Byte/halfword functions, with I = 0x0000ABCD:
  - FunSel 100 → 0x000000CD.
  - FunSel 101 → 0x0000ABCD.
  - FunSel 111 → 0xFFFFFFCD.
  - From R = 0x11223344, FunSel 110 → 0x223344CD.
- Multi-enable and no-bypass: start from R1 = 5, R4 = 9, S1 = 0. Apply RegSel = 1001, ScrSel = 0001, FunSel = 001 in one cycle.
  - Before the edge, OutASel = 000 reads 5.
  - After the edge, R1 = 6, R4 = 10, S1 = 1.
- Reset mid-operation: while incrementing R3 every cycle from 0 (values 1, 2, 3), pull Reset = 0 for one edge. R3 must read 0 on that cycle's output, and the next enabled edge must give 1.
